text_buffer_writer: RTL and testbench

//  Upstream feeder of the 65-char text RAM (8-bit address, 32-bit data, wren) scanned by the VGA path.

---
 rtl/text_pkg.sv | 19 +
 rtl/text_buffer_writer_if.sv | 15 +
 rtl/char_class.sv | 20 ++
 rtl/text_buffer_writer.sv | 152 +++++++++++++++
 tb/tb_text_buffer_writer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared constants and state type for the text buffer writer.
//   TEXT_LEN  number of character cells in the text RAM
//   BS_CODE   backspace code
//   CR_CODE   carriage return, clears the whole screen
//   FILL_CHR  blank written by backspace and clear
package text_pkg;

   localparam int         TEXT_LEN = 65;
   localparam logic [7:0] BS_CODE  = 8'h08;
   localparam logic [7:0] CR_CODE  = 8'h0D;
   localparam logic [7:0] FILL_CHR = 8'h20;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CLEAR = 2'd2
   } wr_state_t;

endpackage

// File: rtl/text_buffer_writer_if.sv
// Character stream handshake into the text buffer writer.
//   in_char   character code
//   in_valid  in_char is valid
//   in_ready  writer can accept; a transfer happens when in_valid & in_ready
// master = character source, slave = text_buffer_writer.
interface text_buffer_writer_if;

   logic [7:0] in_char;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_char, output in_valid, input in_ready);
   modport slave  (input in_char, input in_valid, output in_ready);

endinterface

// File: rtl/char_class.sv
// Combinational classifier for incoming character codes.
//   in_char   code to classify
//   is_print  printable ASCII 0x20..0x7E
//   is_bs     equals BS_CODE
//   is_cr     equals CR_CODE
module char_class #(
   parameter logic [7:0] BS_CODE = text_pkg::BS_CODE,
   parameter logic [7:0] CR_CODE = text_pkg::CR_CODE
) (
   input  logic [7:0] in_char,
   output logic       is_print,
   output logic       is_bs,
   output logic       is_cr
);

   assign is_print = (in_char >= 8'h20) && (in_char <= 8'h7E);
   assign is_bs    = (in_char == BS_CODE);
   assign is_cr    = (in_char == CR_CODE);

endmodule

// File: rtl/text_buffer_writer.sv
// Feeds the text RAM write port from a decoded character stream.
// Printable characters are written at the cursor, backspace blanks the
// previous cell, carriage return or clear_req blanks the whole screen.
//   clock      system clock, all logic on posedge
//   reset      synchronous, active-high
//   in_if      character stream (slave side)
//   clear_req  level request to clear, honoured in IDLE
//   address    RAM address (registered)
//   data       RAM write data {24'b0, char} (registered)
//   wren       RAM write enable, one-cycle pulses
//   cursor     next cell to write, 0..TEXT_LEN
//   full       cursor == TEXT_LEN
//   overflow   one-cycle pulse when a printable char is dropped while full
//   busy       state != IDLE
module text_buffer_writer #(
   parameter int         TEXT_LEN = text_pkg::TEXT_LEN,
   parameter logic [7:0] BS_CODE  = text_pkg::BS_CODE,
   parameter logic [7:0] CR_CODE  = text_pkg::CR_CODE,
   parameter logic [7:0] FILL_CHR = text_pkg::FILL_CHR
) (
   input  logic                  clock,
   input  logic                  reset,
   text_buffer_writer_if.slave   in_if,
   input  logic                  clear_req,
   output logic [7:0]            address,
   output logic [31:0]           data,
   output logic                  wren,
   output logic [7:0]            cursor,
   output logic                  full,
   output logic                  overflow,
   output logic                  busy
);

   import text_pkg::*;

   localparam logic [7:0] LAST = 8'(TEXT_LEN);

   wr_state_t  state_reg, state_next;
   logic [7:0] cursor_reg, cursor_next;
   logic [7:0] idx_reg, idx_next;
   logic [7:0] address_reg, address_next;
   logic [7:0] char_reg, char_next;
   logic       wren_reg, wren_next;
   logic       overflow_reg, overflow_next;

   logic is_print, is_bs, is_cr;
   logic accept;
   logic start_clear;

   char_class #(
      .BS_CODE (BS_CODE),
      .CR_CODE (CR_CODE)
   ) u_char_class (
      .in_char  (in_if.in_char),
      .is_print (is_print),
      .is_bs    (is_bs),
      .is_cr    (is_cr)
   );

   // clear_req blocks acceptance so it wins over a simultaneous character
   assign in_if.in_ready = (state_reg == IDLE) & ~clear_req & ~reset;
   assign accept         = in_if.in_valid & in_if.in_ready;
   assign start_clear    = (state_reg == IDLE) & (clear_req | (accept & is_cr));

   always_comb begin
      state_next    = state_reg;
      cursor_next   = cursor_reg;
      idx_next      = idx_reg;
      address_next  = address_reg;
      char_next     = char_reg;
      wren_next     = 1'b0;
      overflow_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start_clear) begin
               // Cell 0 is issued on the entry edge; idx_reg then names the
               // next cell, so the CLEAR state spans exactly TEXT_LEN cycles.
               state_next   = CLEAR;
               wren_next    = 1'b1;
               address_next = 8'd0;
               char_next    = FILL_CHR;
               idx_next     = 8'd1;
            end else if (accept) begin
               if (is_print) begin
                  if (cursor_reg != LAST) begin
                     state_next   = WRITE;
                     wren_next    = 1'b1;
                     address_next = cursor_reg;
                     char_next    = in_if.in_char;
                     cursor_next  = cursor_reg + 8'd1;
                  end else begin
                     overflow_next = 1'b1;
                  end
               end else if (is_bs && (cursor_reg != 8'd0)) begin
                  state_next   = WRITE;
                  wren_next    = 1'b1;
                  address_next = cursor_reg - 8'd1;
                  char_next    = FILL_CHR;
                  cursor_next  = cursor_reg - 8'd1;
               end
            end
         end
         WRITE: begin
            state_next = IDLE;
         end
         CLEAR: begin
            if (idx_reg == LAST) begin
               state_next  = IDLE;
               cursor_next = 8'd0;
            end else begin
               wren_next    = 1'b1;
               address_next = idx_reg;
               char_next    = FILL_CHR;
               idx_next     = idx_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         cursor_reg   <= 8'd0;
         idx_reg      <= 8'd0;
         address_reg  <= 8'd0;
         char_reg     <= 8'd0;
         wren_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cursor_reg   <= cursor_next;
         idx_reg      <= idx_next;
         address_reg  <= address_next;
         char_reg     <= char_next;
         wren_reg     <= wren_next;
         overflow_reg <= overflow_next;
      end
   end

   assign address  = address_reg;
   assign data     = {24'd0, char_reg};
   assign wren     = wren_reg;
   assign cursor   = cursor_reg;
   assign full     = (cursor_reg == LAST);
   assign overflow = overflow_reg;
   assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_text_buffer_writer.sv
module tb_text_buffer_writer;

   localparam int N = 65;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        clear_req = 1'b0;
   logic [7:0]  address;
   logic [31:0] data;
   logic        wren;
   logic [7:0]  cursor;
   logic        full;
   logic        overflow;
   logic        busy;

   text_buffer_writer_if bus ();

   text_buffer_writer dut (
      .clock     (clock),
      .reset     (reset),
      .in_if     (bus.slave),
      .clear_req (clear_req),
      .address   (address),
      .data      (data),
      .wren      (wren),
      .cursor    (cursor),
      .full      (full),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int ovf_seen = 0;
   int ovf_exp = 0;
   int model_cursor = 0;
   int txn = 0;
   logic [39:0] obs_q[$];
   logic [39:0] exp_q[$];
   logic [7:0]  ram [0:N-1];

   // Write-port monitor: every wren cycle is one RAM write {address, data}
   always @(negedge clock) begin
      if (wren === 1'b1) begin
         obs_q.push_back({address, data});
         if (int'(address) < N) ram[address] = data[7:0];
      end
      if (overflow === 1'b1) ovf_seen++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: observed timeout expected completion", tag);
   endtask

   // Reference model: what the screen writer should do with each code
   task automatic model_clear();
      for (int i = 0; i < N; i++) exp_q.push_back({8'(i), 32'h20});
      model_cursor = 0;
   endtask

   task automatic model_char(input logic [7:0] c);
      if (c >= 8'h20 && c <= 8'h7E) begin
         if (model_cursor < N) begin
            exp_q.push_back({8'(model_cursor), 24'h0, c});
            model_cursor++;
         end else begin
            ovf_exp++;
         end
      end else if (c == 8'h08) begin
         if (model_cursor > 0) begin
            model_cursor--;
            exp_q.push_back({8'(model_cursor), 32'h20});
         end
      end else if (c == 8'h0D) begin
         model_clear();
      end
   endtask

   // Offer a char, wait for acceptance; returns 1 ns after the accepting edge
   task automatic send(input logic [7:0] c);
      int n;
      n = 0;
      @(negedge clock);
      bus.in_char  = c;
      bus.in_valid = 1'b1;
      #1;
      while (bus.in_ready !== 1'b1 && n < 300) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (n >= 300) timeout_fail("accept_timeout");
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      model_char(c);
      txn++;
      $display("txn %0d: char %02h model_cursor %0d", txn, c, model_cursor);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge clock);
      while (busy !== 1'b0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (n >= 300) timeout_fail({tag, "_idle_timeout"});
      chk({tag, "_cursor"}, 64'(cursor), 64'(model_cursor));
      chk({tag, "_full"}, 64'(full), 64'(model_cursor == N));
   endtask

   task automatic compare_writes(input string tag);
      int m;
      chk({tag, "_write_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) chk({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int r;
      logic [7:0] c;

      bus.in_char  = 8'h00;
      bus.in_valid = 1'b0;

      // 1: reset for three cycles
      repeat (3) begin
         @(negedge clock);
         chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
         chk("rst_wren", 64'(wren), 64'd0);
         chk("rst_cursor", 64'(cursor), 64'd0);
      end
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("post_rst_address", 64'(address), 64'd0);
      chk("post_rst_data", 64'(data), 64'd0);
      chk("post_rst_overflow", 64'(overflow), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);

      // 2: 'H', 'I'
      send(8'h48);
      chk("h_in_ready_write", 64'(bus.in_ready), 64'd0);
      chk("h_wren", 64'(wren), 64'd1);
      chk("h_address", 64'(address), 64'd0);
      chk("h_data", 64'(data), 64'h48);
      send(8'h49);
      chk("i_in_ready_write", 64'(bus.in_ready), 64'd0);
      chk("i_address", 64'(address), 64'd1);
      chk("i_data", 64'(data), 64'h49);
      wait_idle("hi");
      chk("hi_cursor_2", 64'(cursor), 64'd2);
      compare_writes("hi");

      // 3: backspace down to and past zero
      send(8'h08);
      chk("bs_address", 64'(address), 64'd1);
      chk("bs_data", 64'(data), 64'h20);
      wait_idle("bs1");
      send(8'h08);
      wait_idle("bs2");
      send(8'h08);
      wait_idle("bs0");
      chk("bs0_cursor", 64'(cursor), 64'd0);
      compare_writes("bs");

      // 4: fill to full, then one more printable
      ovf_seen = 0;
      ovf_exp  = 0;
      for (int i = 0; i < N; i++) send(8'h41);
      wait_idle("fill");
      send(8'h42);
      chk("ovf_pulse", 64'(overflow), 64'd1);
      chk("ovf_no_wren", 64'(wren), 64'd0);
      wait_idle("ovf");
      repeat (2) @(negedge clock);
      chk("ovf_count", 64'(ovf_seen), 64'(ovf_exp));
      chk("full_flag", 64'(full), 64'd1);
      compare_writes("fill");

      // 5: clear_req wins over a simultaneous char
      @(negedge clock);
      clear_req    = 1'b1;
      bus.in_char  = 8'h5A;
      bus.in_valid = 1'b1;
      #1;
      chk("clr_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clock);
      #1;
      clear_req    = 1'b0;
      bus.in_valid = 1'b0;
      model_clear();
      txn++;
      $display("txn %0d: clear_req with char 5a offered", txn);
      chk("clr_busy", 64'(busy), 64'd1);
      n = 0;
      forever begin
         @(negedge clock);
         if (busy !== 1'b1 || n >= 300) break;
         n++;
      end
      chk("clr_busy_cycles_ge_len", 64'(n >= N), 64'd1);
      wait_idle("clr");
      compare_writes("clr");

      // 6: reset in the middle of a clear
      for (int i = 0; i < 12; i++) send(8'h51);
      wait_idle("q");
      compare_writes("q");
      send(8'h0D);
      n = 0;
      forever begin
         @(negedge clock);
         if ((wren === 1'b1 && address === 8'd10) || n >= 200) break;
         n++;
      end
      if (n >= 200) timeout_fail("clr_k10_timeout");
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("abort_wren", 64'(wren), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_cursor", 64'(cursor), 64'd0);
      chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) chk("abort_cell_blank", 64'(ram[i]), 64'h20);
      chk("abort_cell11_kept", 64'(ram[11]), 64'h51);
      obs_q.delete();
      exp_q.delete();
      model_cursor = 0;

      // 7: randomized traffic against the model
      ovf_seen = 0;
      ovf_exp  = 0;
      for (int op = 0; op < 250; op++) begin
         r = int'($urandom_range(0, 99));
         if (r < 90) begin
            if (r < 62)      c = 8'($urandom_range(32, 126));
            else if (r < 80) c = 8'h08;
            else if (r < 82) c = 8'h0D;
            else             c = 8'($urandom_range(127, 255));
            send(c);
         end else begin
            @(negedge clock);
            clear_req = 1'b1;
            @(posedge clock);
            #1;
            clear_req = 1'b0;
            model_clear();
            txn++;
            $display("txn %0d: clear_req pulse", txn);
         end
         wait_idle("rnd");
         if (op % 25 == 24) compare_writes("rnd");
      end
      repeat (2) @(negedge clock);
      compare_writes("rnd_end");
      chk("rnd_ovf_count", 64'(ovf_seen), 64'(ovf_exp));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
